// File: rtl/key_press_classifier.sv
// key_press_classifier
//
// Classifies a single held key code into press / long-press / auto-repeat /
// release events for a small set of mapped keys. The raw key input is only
// looked at on slow sampling ticks produced by an internal prescaler, so the
// debounce and long-press thresholds are expressed in ticks, not clocks.
//
// Ports:
//   clk           - single clock, all logic on its rising edge
//   reset         - synchronous, active-high reset
//   key_valid     - a key is currently held
//   key_code      - code of the held key (ignored when key_valid=0)
//   key_state     - per-key state, 2 bits per key: 0 idle, 1 short, 2 long
//   press_pulse   - one-cycle pulse when a press is confirmed
//   long_pulse    - one-cycle pulse on entry to long press
//   repeat_pulse  - one-cycle auto-repeat pulse while in long press
//   release_short - one-cycle pulse on release from short press
//   release_long  - one-cycle pulse on release from long press

module key_press_classifier #(
   parameter int                          NUM_KEYS       = 6,
   parameter int                          CODE_W         = 4,
   parameter logic [NUM_KEYS*CODE_W-1:0]  KEY_CODES      = {4'hf, 4'hc, 4'h3, 4'h0, 4'h5, 4'hd},
   parameter int                          TICK_DIV       = 50000,
   parameter int                          DEBOUNCE_TICKS = 20,
   parameter int                          LONG_TICKS     = 1000,
   parameter int                          REPEAT_TICKS   = 200,
   parameter int                          REPEAT_EN      = 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    key_valid,
   input  logic [CODE_W-1:0]       key_code,
   output logic [2*NUM_KEYS-1:0]   key_state,
   output logic [NUM_KEYS-1:0]     press_pulse,
   output logic [NUM_KEYS-1:0]     long_pulse,
   output logic [NUM_KEYS-1:0]     repeat_pulse,
   output logic [NUM_KEYS-1:0]     release_short,
   output logic [NUM_KEYS-1:0]     release_long
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = $clog2(LONG_TICKS + 1);
   localparam int RW = $clog2(REPEAT_TICKS + 1);
   localparam int IW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;

   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] DEB_LIMIT  = CW'(DEBOUNCE_TICKS);
   localparam logic [CW-1:0] LONG_LIMIT = CW'(LONG_TICKS);
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [RW-1:0] REP_LIMIT  = RW'(REPEAT_TICKS);
   localparam logic [RW-1:0] REP_ONE    = RW'(1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      DEBOUNCE = 2'd1,
      PRESSED  = 2'd2,
      LONG     = 2'd3
   } state_t;

   logic [PW-1:0]         presc;
   logic                  tick;
   state_t                state;
   logic [IW-1:0]         cur;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_inc;
   logic [RW-1:0]         rep_cnt;
   logic [RW-1:0]         rep_inc;
   logic                  hit;
   logic [IW-1:0]         hit_idx;
   state_t                start_state;
   logic [2*NUM_KEYS-1:0] start_key_state;
   logic [NUM_KEYS-1:0]   start_press;

   // One-hot vector selecting key k, used for every pulse output.
   function automatic logic [NUM_KEYS-1:0] onehot(input logic [IW-1:0] k);
      onehot    = '0;
      onehot[k] = 1'b1;
   endfunction

   // Full key_state vector with only key k carrying state code s.
   function automatic logic [2*NUM_KEYS-1:0] state_vec(input logic [IW-1:0] k,
                                                      input logic [1:0]    s);
      state_vec                 = '0;
      state_vec[{k, 1'b0} +: 2] = s;
   endfunction

   assign tick    = (presc == PRESC_LAST);
   assign cnt_inc = cnt + CNT_ONE;
   assign rep_inc = rep_cnt + REP_ONE;

   // Sampling-tick prescaler: counts 0..TICK_DIV-1 and wraps; with TICK_DIV=1
   // it sits at zero and every cycle is a tick.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   // Code-to-key lookup. Scanning from the highest index down lets the lowest
   // matching index overwrite the others, so duplicate map entries resolve to
   // the lowest key. Unmapped codes simply produce no hit (treated as released).
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int k = NUM_KEYS - 1; k >= 0; k--) begin
         if (key_valid && (key_code == KEY_CODES[k*CODE_W +: CODE_W])) begin
            hit     = 1'b1;
            hit_idx = IW'(k);
         end
      end
   end

   // What "start tracking the newly matched key" means. With a one-tick
   // debounce the very first matching tick already confirms the press, so the
   // DEBOUNCE state is skipped entirely.
   always_comb begin
      start_state     = DEBOUNCE;
      start_key_state = '0;
      start_press     = '0;
      if (DEBOUNCE_TICKS == 1) begin
         start_state     = PRESSED;
         start_key_state = state_vec(hit_idx, 2'd1);
         start_press     = onehot(hit_idx);
      end
   end

   // Main classifier FSM. Pulses default low every cycle and are only raised
   // on a tick edge, so each lasts exactly one clk cycle. key_state is only
   // rewritten on tick edges and holds in between. A key change while pressed
   // is treated as a release of the old key plus a fresh debounce of the new.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         cur           <= '0;
         cnt           <= '0;
         rep_cnt       <= '0;
         key_state     <= '0;
         press_pulse   <= '0;
         long_pulse    <= '0;
         repeat_pulse  <= '0;
         release_short <= '0;
         release_long  <= '0;
      end else begin
         press_pulse   <= '0;
         long_pulse    <= '0;
         repeat_pulse  <= '0;
         release_short <= '0;
         release_long  <= '0;
         if (tick) begin
            case (state)
               IDLE: begin
                  if (hit) begin
                     state       <= start_state;
                     cur         <= hit_idx;
                     cnt         <= CNT_ONE;
                     key_state   <= start_key_state;
                     press_pulse <= start_press;
                  end
               end

               DEBOUNCE: begin
                  if (!hit) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (hit_idx != cur) begin
                     state       <= start_state;
                     cur         <= hit_idx;
                     cnt         <= CNT_ONE;
                     key_state   <= start_key_state;
                     press_pulse <= start_press;
                  end else begin
                     cnt <= cnt_inc;
                     if (cnt_inc >= DEB_LIMIT) begin
                        state       <= PRESSED;
                        key_state   <= state_vec(cur, 2'd1);
                        press_pulse <= onehot(cur);
                     end
                  end
               end

               PRESSED: begin
                  if (!hit) begin
                     state         <= IDLE;
                     cnt           <= '0;
                     key_state     <= '0;
                     release_short <= onehot(cur);
                  end else if (hit_idx != cur) begin
                     release_short <= onehot(cur);
                     state         <= start_state;
                     cur           <= hit_idx;
                     cnt           <= CNT_ONE;
                     key_state     <= start_key_state;
                     press_pulse   <= start_press;
                  end else begin
                     cnt <= cnt_inc;
                     if (cnt_inc >= LONG_LIMIT) begin
                        state      <= LONG;
                        rep_cnt    <= '0;
                        key_state  <= state_vec(cur, 2'd2);
                        long_pulse <= onehot(cur);
                     end
                  end
               end

               LONG: begin
                  if (!hit) begin
                     state        <= IDLE;
                     cnt          <= '0;
                     rep_cnt      <= '0;
                     key_state    <= '0;
                     release_long <= onehot(cur);
                  end else if (hit_idx != cur) begin
                     release_long <= onehot(cur);
                     state        <= start_state;
                     cur          <= hit_idx;
                     cnt          <= CNT_ONE;
                     rep_cnt      <= '0;
                     key_state    <= start_key_state;
                     press_pulse  <= start_press;
                  end else begin
                     if (cnt < LONG_LIMIT) begin
                        cnt <= cnt_inc;
                     end
                     if (REPEAT_EN != 0) begin
                        if (rep_inc >= REP_LIMIT) begin
                           rep_cnt      <= '0;
                           repeat_pulse <= onehot(cur);
                        end else begin
                           rep_cnt <= rep_inc;
                        end
                     end
                  end
               end

               default: begin
                  state     <= IDLE;
                  cnt       <= '0;
                  rep_cnt   <= '0;
                  key_state <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_press_classifier.sv
// tb_key_press_classifier
//
// Bench for key_press_classifier built with a fast tick (TICK_DIV=4),
// DEBOUNCE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2 and the default key map.
// Two copies are driven from the same inputs: one with auto-repeat enabled and
// one with it disabled. Per-tick expectations come from a hand-written table;
// each expected record is queued when its stimulus is driven and popped when
// the tick edge that consumes it has produced outputs.

module tb_key_press_classifier;

   localparam int NK = 6;

   typedef struct {
      logic        valid;
      logic [3:0]  code;
      logic [11:0] st;
      logic [5:0]  pp;
      logic [5:0]  lp;
      logic [5:0]  rp;
      logic [5:0]  rs;
      logic [5:0]  rl;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        key_valid;
   logic [3:0]  key_code;

   logic [11:0] st1, st0;
   logic [5:0]  pp1, lp1, rp1, rs1, rl1;
   logic [5:0]  pp0, lp0, rp0, rs0, rl0;

   vec_t tbl[$];
   vec_t sb[$];

   int errors = 0;
   int checks = 0;

   logic [1:0] tb_presc;
   logic       tb_tick;

   int rep0_cnt  = 0;
   int rep1_cnt  = 0;
   int long0_cnt = 0;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   key_press_classifier #(
      .NUM_KEYS(NK), .CODE_W(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3),
      .LONG_TICKS(8), .REPEAT_TICKS(2), .REPEAT_EN(1)
   ) u_dut (
      .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
      .key_state(st1), .press_pulse(pp1), .long_pulse(lp1),
      .repeat_pulse(rp1), .release_short(rs1), .release_long(rl1)
   );

   key_press_classifier #(
      .NUM_KEYS(NK), .CODE_W(4), .TICK_DIV(4), .DEBOUNCE_TICKS(3),
      .LONG_TICKS(8), .REPEAT_TICKS(2), .REPEAT_EN(0)
   ) u_dut_norep (
      .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
      .key_state(st0), .press_pulse(pp0), .long_pulse(lp0),
      .repeat_pulse(rp0), .release_short(rs0), .release_long(rl0)
   );

   // Independent model of the tick timing: tb_tick is high right after an edge
   // on which the design should have sampled its inputs.
   always @(posedge clk) begin
      if (reset) begin
         tb_presc <= 2'd0;
         tb_tick  <= 1'b0;
      end else begin
         tb_tick  <= (tb_presc == 2'd3);
         tb_presc <= tb_presc + 2'd1;
      end
   end

   // Pulse counters sampled mid-cycle, used for the repeat-disable checks.
   always @(negedge clk) begin
      if (|rp0) rep0_cnt++;
      if (|rp1) rep1_cnt++;
      if (|lp0) long0_cnt++;
   end

   // Hard time limit so the bench can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "[TB] aborted");
   end

   function automatic logic [41:0] pk(input logic [11:0] st, input logic [5:0] pp,
                                      input logic [5:0] lp, input logic [5:0] rp,
                                      input logic [5:0] rs, input logic [5:0] rl);
      return {st, pp, lp, rp, rs, rl};
   endfunction

   task automatic check(input string name, input logic [41:0] got, input logic [41:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic check_int(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [3:0] c, input logic [11:0] st,
                               input logic [5:0] pp, input logic [5:0] lp, input logic [5:0] rp,
                               input logic [5:0] rs, input logic [5:0] rl);
      vec_t r;
      r.valid = v; r.code = c; r.st = st;
      r.pp = pp; r.lp = lp; r.rp = rp; r.rs = rs; r.rl = rl;
      return r;
   endfunction

   task automatic add(input logic v, input logic [3:0] c, input logic [11:0] st,
                      input logic [5:0] pp, input logic [5:0] lp, input logic [5:0] rp,
                      input logic [5:0] rs, input logic [5:0] rl);
      tbl.push_back(mk(v, c, st, pp, lp, rp, rs, rl));
   endtask

   // Drive one tick's worth of input, queue its expectation, then wait for the
   // tick edge that samples it (bounded).
   task automatic applyStimulus(input vec_t v);
      int guard;
      key_valid = v.valid;
      key_code  = v.code;
      sb.push_back(v);
      guard = 0;
      do begin
         @(posedge clk);
         #1;
         guard++;
      end while (!tb_tick && guard < 8);
      if (!tb_tick) begin
         checks++;
         errors++;
         $display("[TB] FAIL tick_wait got=no_tick exp=tick_within_8_cycles");
      end
   endtask

   // Compare both designs against the oldest queued expectation, then check
   // that pulses have dropped one cycle later while key_state holds.
   task automatic checkOutput(input string name);
      vec_t e;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s got=empty_scoreboard exp=entry", name);
      end else begin
         e = sb.pop_front();
         check({name, "_rep"},   pk(st1, pp1, lp1, rp1, rs1, rl1),
               pk(e.st, e.pp, e.lp, e.rp, e.rs, e.rl));
         check({name, "_norep"}, pk(st0, pp0, lp0, rp0, rs0, rl0),
               pk(e.st, e.pp, e.lp, 6'h00, e.rs, e.rl));
         @(posedge clk);
         #1;
         check({name, "_clr_rep"},   pk(st1, pp1, lp1, rp1, rs1, rl1), {e.st, 30'b0});
         check({name, "_clr_norep"}, pk(st0, pp0, lp0, rp0, rs0, rl0), {e.st, 30'b0});
      end
   endtask

   initial begin
      int   long0_before;
      int   rep1_before;
      vec_t v;

      reset     = 1'b1;
      key_valid = 1'b0;
      key_code  = 4'h0;

      // Key1 (code 5): short press then release.
      add(1, 4'h5, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'h5, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'h5, 12'h004, 6'h02, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'h5, 12'h004, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'h5, 12'h004, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h02, 6'h00);
      // Key0 (code d): 13 ticks into long press with repeats, then release.
      add(1, 4'hd, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hd, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hd, 12'h001, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
      for (int i = 0; i < 4; i++) add(1, 4'hd, 12'h001, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hd, 12'h002, 6'h00, 6'h01, 6'h00, 6'h00, 6'h00);
      add(1, 4'hd, 12'h002, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hd, 12'h002, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00);
      add(1, 4'hd, 12'h002, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hd, 12'h002, 6'h00, 6'h00, 6'h01, 6'h00, 6'h00);
      add(1, 4'hd, 12'h002, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01);
      // key_valid low with a mapped code, a too-short hold, and an unmapped code.
      for (int i = 0; i < 3; i++)  add(0, 4'hd, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      for (int i = 0; i < 2; i++)  add(1, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      for (int i = 0; i < 10; i++) add(1, 4'h7, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      // Key3 pressed, switch to key4: release_short[3], fresh debounce of key4.
      add(1, 4'h3, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'h3, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'h3, 12'h040, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hc, 12'h000, 6'h00, 6'h00, 6'h00, 6'h08, 6'h00);
      add(1, 4'hc, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hc, 12'h100, 6'h10, 6'h00, 6'h00, 6'h00, 6'h00);
      add(0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h10, 6'h00);
      // Key change during debounce restarts the count silently.
      add(1, 4'hd, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hd, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hf, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hf, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hf, 12'h400, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00);
      add(0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h20, 6'h00);
      // Key5 to long press, then switch to key0: release_long[5].
      add(1, 4'hf, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hf, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hf, 12'h400, 6'h20, 6'h00, 6'h00, 6'h00, 6'h00);
      for (int i = 0; i < 4; i++) add(1, 4'hf, 12'h400, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hf, 12'h800, 6'h00, 6'h20, 6'h00, 6'h00, 6'h00);
      add(1, 4'hf, 12'h800, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hf, 12'h800, 6'h00, 6'h00, 6'h20, 6'h00, 6'h00);
      add(1, 4'hd, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h20);
      add(1, 4'hd, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00);
      add(1, 4'hd, 12'h001, 6'h01, 6'h00, 6'h00, 6'h00, 6'h00);
      add(0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h01, 6'h00);

      repeat (3) @(posedge clk);
      #1;
      check("reset_state_rep",   pk(st1, pp1, lp1, rp1, rs1, rl1), 42'h0);
      check("reset_state_norep", pk(st0, pp0, lp0, rp0, rs0, rl0), 42'h0);
      reset = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("vec%0d", i));
      end

      // Reset while key5 is in long press: everything clears, no release pulse,
      // and the first tick after reset lands 4 cycles later.
      for (int t = 1; t <= 8; t++) begin
         v = mk(1, 4'hf,
                (t < 3) ? 12'h000 : ((t < 8) ? 12'h400 : 12'h800),
                (t == 3) ? 6'h20 : 6'h00,
                (t == 8) ? 6'h20 : 6'h00,
                6'h00, 6'h00, 6'h00);
         applyStimulus(v);
         checkOutput($sformatf("k5long%0d", t));
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_in_long_rep",   pk(st1, pp1, lp1, rp1, rs1, rl1), 42'h0);
      check("reset_in_long_norep", pk(st0, pp0, lp0, rp0, rs0, rl0), 42'h0);
      reset = 1'b0;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_reset_cyc%0d", e), pk(st1, pp1, lp1, rp1, rs1, rl1),
               pk((e == 12) ? 12'h400 : 12'h000, (e == 12) ? 6'h20 : 6'h00,
                  6'h00, 6'h00, 6'h00, 6'h00));
      end
      applyStimulus(mk(0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h20, 6'h00));
      checkOutput("post_reset_release");

      // 20-tick hold of key0: the repeat-disabled copy gives one long pulse
      // and never repeats; the enabled copy repeats on every second tick.
      long0_before = long0_cnt;
      rep1_before  = rep1_cnt;
      for (int t = 1; t <= 20; t++) begin
         v = mk(1, 4'hd,
                (t < 3) ? 12'h000 : ((t < 8) ? 12'h001 : 12'h002),
                (t == 3) ? 6'h01 : 6'h00,
                (t == 8) ? 6'h01 : 6'h00,
                (t >= 10 && (t % 2) == 0) ? 6'h01 : 6'h00,
                6'h00, 6'h00);
         applyStimulus(v);
         checkOutput($sformatf("hold20_t%0d", t));
      end
      applyStimulus(mk(0, 4'h0, 12'h000, 6'h00, 6'h00, 6'h00, 6'h00, 6'h01));
      checkOutput("hold20_release");
      check_int("norep_long_count", long0_cnt - long0_before, 1);
      check_int("rep_repeat_count", rep1_cnt - rep1_before, 6);
      check_int("norep_repeat_total", rep0_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_press_classifier.md
KEY_PRESS_CLASSIFIER -- requirements
Module: key_press_classifier

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 6: number of classified keys.
REQ-002 SHALL have parameter CODE_W, default 4: width of key_code.
REQ-003 SHALL have parameter KEY_CODES, default {4'hf,4'hc,4'h3,4'h0,4'h5,4'hd}: packed NUM_KEYS*CODE_W code map, with key k in bits [k*CODE_W +: CODE_W], so key0=4'hd.
REQ-004 SHALL have parameter TICK_DIV, default 50000: clk cycles per sampling tick, minimum 1.
REQ-005 SHALL have parameter DEBOUNCE_TICKS, default 20: consecutive held ticks needed to confirm a press, minimum 1.
REQ-006 SHALL have parameter LONG_TICKS, default 1000: held ticks needed to reach long press, greater than DEBOUNCE_TICKS.
REQ-007 SHALL have parameter REPEAT_TICKS, default 200: auto-repeat period in ticks while in long press, minimum 1.
REQ-008 SHALL have parameter REPEAT_EN, default 1: 1 enables auto-repeat pulses.
REQ-009 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-010 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-011 SHALL have port key_valid, input, 1 bit: a key is currently held.
REQ-012 SHALL have port key_code, input, CODE_W bits: code of the held key; ignored when key_valid=0.
REQ-013 SHALL have port key_state, output, 2*NUM_KEYS bits: per-key state in bits [2k+1:2k], where 0=idle, 1=short press, 2=long press.
REQ-014 SHALL have port press_pulse, output, NUM_KEYS bits: one-cycle pulse when a press is confirmed.
REQ-015 SHALL have port long_pulse, output, NUM_KEYS bits: one-cycle pulse on entry to long press.
REQ-016 SHALL have port repeat_pulse, output, NUM_KEYS bits: one-cycle auto-repeat pulse.
REQ-017 SHALL have port release_short, output, NUM_KEYS bits: one-cycle pulse on release from short press.
REQ-018 SHALL have port release_long, output, NUM_KEYS bits: one-cycle pulse on release from long press.

Function
REQ-019 Prescaler SHALL count 0..TICK_DIV-1 and wrap; tick=1 exactly when count==TICK_DIV-1; TICK_DIV=1 gives tick every cycle.
REQ-020 Inputs SHALL be sampled and FSM SHALL update only on clk edges where tick=1; all outputs SHALL be registered, and pulses SHALL be high only for the one clk cycle after that edge.
REQ-021 Code match: key_valid=1 and key_code equals the KEY_CODES entry for key k; on duplicate entries the lowest k SHALL win; unmapped codes SHALL count as released.
REQ-022 FSM SHALL have states IDLE, DEBOUNCE, PRESSED, LONG, plus an active-key index cur and a saturating hold counter cnt.
REQ-023 IDLE: on a matching key k, SHALL go to DEBOUNCE with cur=k and cnt=1; otherwise SHALL stay in IDLE.
REQ-024 DEBOUNCE, same key held: cnt SHALL increment; when cnt reaches DEBOUNCE_TICKS, SHALL go to PRESSED and pulse press_pulse[cur]. With DEBOUNCE_TICKS=1, SHALL go directly from IDLE to PRESSED and pulse press_pulse on the first matching tick.
REQ-025 DEBOUNCE, key released: SHALL return to IDLE with no pulse.
REQ-026 DEBOUNCE, other mapped key: SHALL restart DEBOUNCE for the new key with cnt=1, with no pulse.
REQ-027 PRESSED, same key held: cnt SHALL increment; when cnt reaches LONG_TICKS, SHALL go to LONG, pulse long_pulse[cur], and clear the repeat counter.
REQ-028 PRESSED, key released: SHALL go to IDLE and pulse release_short[cur].
REQ-029 PRESSED, other mapped key: SHALL pulse release_short for the old key and enter DEBOUNCE for the new key with cnt=1.
REQ-030 LONG, same key held, REPEAT_EN=1: the repeat counter SHALL increment; on reaching REPEAT_TICKS it SHALL pulse repeat_pulse[cur] and clear; cnt SHALL saturate, never wrap.
REQ-031 LONG, key released: SHALL go to IDLE and pulse release_long[cur].
REQ-032 LONG, other mapped key: SHALL pulse release_long for the old key and enter DEBOUNCE for the new key.
REQ-033 key_state SHALL be 1 for cur in PRESSED, 2 for cur in LONG, and 0 for all other keys and in IDLE/DEBOUNCE.
REQ-034 At most one key SHALL be non-idle, and at most one bit per pulse vector SHALL be set, in any cycle.
REQ-035 With REPEAT_EN=0, repeat_pulse SHALL stay 0.

Reset
REQ-036 While reset=1 at a clk edge: prescaler=0, FSM=IDLE, cnt=0, repeat counter=0, and all outputs SHALL be 0 in the following cycle.
REQ-037 Reset during PRESSED or LONG SHALL produce no release pulse; the first tick after reset deasserts SHALL occur TICK_DIV cycles later.

Verification (TICK_DIV=4, DEBOUNCE_TICKS=3, LONG_TICKS=8, REPEAT_TICKS=2, default KEY_CODES)
REQ-038 Hold code 4'h5 for 5 ticks then release -> press_pulse[1] at tick 3; key_state[3:2]=1; release_short[1] on the release tick; no long_pulse.
REQ-039 Hold 4'hd for 13 ticks -> press_pulse[0] at tick 3, long_pulse[0] at tick 8, repeat_pulse[0] at ticks 10 and 12; release -> release_long[0] and key_state=0.
REQ-040 Hold 4'h0 for 2 ticks, release; also hold code 4'h7 for 10 ticks -> no pulses; key_state stays 0.
REQ-041 Hold 4'h3 to PRESSED, switch key_code to 4'hc -> release_short[3], then press_pulse[4] three ticks later.
REQ-042 Assert reset while in LONG for key 5 -> all outputs 0 next cycle; no release_long; after reset deasserts, the first tick occurs 4 cycles later.
REQ-043 Rebuild with REPEAT_EN=0 and hold key 0 for 20 ticks -> long_pulse once; repeat_pulse never asserts.
